fifo_top: RTL and testbench

FIFO_TOP -- requirements
Module: fifo_top

---
 rtl/fifo_top.sv | 80 ++++++++
 tb/tb_fifo_top.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_top.sv
// Single-clock show-ahead FIFO with registered full/empty flags.
// Define FIFO_TOP_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_top #(
    parameter int WSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [WSIZE-1:0] wdata,
    output logic             wfull,
    input  logic             rinc,
    output logic [WSIZE-1:0] rdata,
    output logic             rempty,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW    = ASIZE - 1;
    localparam int DEPTH = 1 << AW;

    logic [WSIZE-1:0] mem [DEPTH];
    logic [ASIZE-1:0] wptr, rptr;
    logic [ASIZE-1:0] wptr_next, rptr_next;
    logic             push, pop;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        push      = winc && !wfull;
        pop       = rinc && !rempty;
        wptr_next = wptr + ASIZE'(push);
        rptr_next = rptr + ASIZE'(pop);
    end

    // Flags are computed from the next-state pointers so they are valid
    // in the cycle right after the causing edge.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            wfull  <= 1'b0;
        end else begin
            wptr   <= wptr_next;
            rptr   <= rptr_next;
            rempty <= (wptr_next == rptr_next);
            wfull  <= (wptr_next == {~rptr_next[ASIZE-1], rptr_next[AW-1:0]});
        end
    end

    // NOTE: storage is deliberately not reset; resetting the pointers empties the queue.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rptr[AW-1:0]];

`ifdef FIFO_TOP_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull) begin
                overflow <= 1'b1;
            end
            if (rinc && rempty) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_top.sv
// Self-checking bench for fifo_top: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fifo_top;

    localparam int WSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 1 << (ASIZE - 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             winc = 1'b0;
    logic [WSIZE-1:0] wdata = '0;
    logic             wfull;
    logic             rinc = 1'b0;
    logic [WSIZE-1:0] rdata;
    logic             rempty;
    logic             overflow;
    logic             underflow;

    fifo_top #(.WSIZE(WSIZE), .ASIZE(ASIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .winc      (winc),
        .wdata     (wdata),
        .wfull     (wfull),
        .rinc      (rinc),
        .rdata     (rdata),
        .rempty    (rempty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the queue contents plus sticky error flags.
    logic [WSIZE-1:0] q[$];
    logic             ovf_m = 1'b0;
    logic             unf_m = 1'b0;

    // DUT head word seen just before the last edge, and whether that edge popped.
    logic [WSIZE-1:0] head_at_edge;
    bit               popped;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".rempty"}, 32'(rempty), 32'(q.size() == 0));
        check({tag, ".wfull"}, 32'(wfull), 32'(q.size() == DEPTH));
        check({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
        check({tag, ".underflow"}, 32'(underflow), 32'(unf_m));
        if (q.size() != 0) begin
            check({tag, ".rdata"}, 32'(rdata), 32'(q[0]));
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, check at negedge.
    task automatic step(input logic rs, input logic w, input logic [WSIZE-1:0] d,
                        input logic r, input string tag);
        bit full_b;
        bit empty_b;
        rst_n = rs;
        winc  = w;
        wdata = d;
        rinc  = r;
        #1;
        head_at_edge = rdata;
        @(posedge clk);
        full_b  = (q.size() == DEPTH);
        empty_b = (q.size() == 0);
        popped  = 1'b0;
        if (!rs) begin
            q.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end else begin
`ifdef FIFO_TOP_ERR_FLAGS_EN
            if (w && full_b) ovf_m = 1'b1;
            if (r && empty_b) unf_m = 1'b1;
`endif
            if (r && !empty_b) begin
                void'(q.pop_front());
                popped = 1'b1;
            end
            if (w && !full_b) q.push_back(d);
        end
        @(negedge clk);
        check_state(tag);
    endtask

    initial begin
        int next_word;
        int expect_word;
        int guard;

        // Reset held 4 cycles with a push request that must be ignored.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hAA, 1'b1, "reset");

        // Fill 0..7; rempty drops after the first push, wfull rises after the 8th.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, WSIZE'(i), 1'b0, "fill");
        check("fill_full", 32'(wfull), 32'd1);

        // Push while full is dropped; drain must return 0..7 only.
        step(1'b1, 1'b1, 8'd99, 1'b0, "push_full");
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1, "drain");
            check("drain_order", 32'(head_at_edge), 32'(i));
        end
        check("drain_empty", 32'(rempty), 32'd1);

        // Pop from empty is dropped; then push 5 and pop it back.
        step(1'b1, 1'b0, 8'h00, 1'b1, "pop_empty");
        step(1'b1, 1'b1, 8'd5, 1'b0, "push5");
        check("push5_head", 32'(rdata), 32'd5);
        step(1'b1, 1'b0, 8'h00, 1'b1, "pop5");
        check("pop5_word", 32'(head_at_edge), 32'd5);

        // Four entries, then 10 cycles of simultaneous push/pop.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, WSIZE'(8'h40 + i), 1'b0, "pre4");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, WSIZE'(8'h50 + i), 1'b1, "both");
            check("both_order", 32'(head_at_edge), (i < 4) ? 32'(8'h40 + i) : 32'(8'h50 + i - 4));
        end
        check("both_occupancy", 32'(q.size()), 32'd4);

        // Top up to full, then push+pop together: only the pop happens.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, WSIZE'(8'h60 + i), 1'b0, "topup");
        check("topup_full", 32'(wfull), 32'd1);
        step(1'b1, 1'b1, 8'hEE, 1'b1, "both_full");
        check("both_full_wfull", 32'(wfull), 32'd0);

        // Clear, then stream 0..39 with random interleaving across many wraps.
        step(1'b0, 1'b0, 8'h00, 1'b0, "clear");
        next_word   = 0;
        expect_word = 0;
        guard       = 0;
        while (expect_word < 40 && guard < 2000) begin
            logic w;
            logic r;
            w = (next_word < 40) && ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 50);
            step(1'b1, w, WSIZE'(next_word), r, "stream");
            if (w && wfull === 1'b0 && !(q.size() == 0 && !w)) begin
                // advance only when the model accepted the word
            end
            if (q.size() != 0 && q[q.size()-1] == WSIZE'(next_word) && w) next_word++;
            if (popped) begin
                check("stream_order", 32'(head_at_edge), 32'(expect_word));
                expect_word++;
            end
            guard++;
        end
        check("stream_done", 32'(expect_word), 32'd40);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) != 0), $urandom_range(0, 1) == 1,
                 WSIZE'($urandom), $urandom_range(0, 1) == 1, "random");
        end

        // Five queued entries, then a 1-cycle reset discards them.
        step(1'b0, 1'b0, 8'h00, 1'b0, "pre_clear");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, WSIZE'(8'h70 + i), 1'b0, "q5");
        step(1'b0, 1'b0, 8'h00, 1'b0, "mid_reset");
        check("mid_reset_rempty", 32'(rempty), 32'd1);
        check("mid_reset_wfull", 32'(wfull), 32'd0);
        step(1'b1, 1'b1, 8'h3C, 1'b0, "after_reset");
        check("after_reset_head", 32'(rdata), 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
